// File: rtl/pipeline_skid_buffer.sv
// Two-entry elastic valid/ready stage (output reg + skid reg), 1-cycle latency, full throughput.
// S_READY is registered, so there is no combinational path from M_READY to S_READY.
module pipeline_skid_buffer #(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  S_VALID,
  output logic                  S_READY,
  input  logic [DATA_WIDTH-1:0] S_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic [1:0]            OCCUPANCY
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_s_ready;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic [1:0]            r_occupancy;

  logic w_accept;
  logic w_drain;

  assign w_accept = S_VALID & r_s_ready;
  assign w_drain  = r_m_valid & M_READY;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_EMPTY;
      r_s_ready   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_out_data  <= RESET_DATA;
      r_skid_data <= RESET_DATA;
      r_occupancy <= 2'd0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          // S_READY is held low for exactly one edge after reset release.
          r_s_ready <= 1'b1;
          if (w_accept) begin
            r_out_data  <= S_DATA;
            r_m_valid   <= 1'b1;
            r_state     <= ST_BUSY;
            r_occupancy <= 2'd1;
          end
        end
        ST_BUSY: begin
          if (w_accept && w_drain) begin
            r_out_data <= S_DATA;
          end else if (w_accept) begin
            r_skid_data <= S_DATA;
            r_s_ready   <= 1'b0;
            r_state     <= ST_FULL;
            r_occupancy <= 2'd2;
          end else if (w_drain) begin
            r_m_valid   <= 1'b0;
            r_state     <= ST_EMPTY;
            r_occupancy <= 2'd0;
          end
        end
        ST_FULL: begin
          if (w_drain) begin
            r_out_data  <= r_skid_data;
            r_s_ready   <= 1'b1;
            r_state     <= ST_BUSY;
            r_occupancy <= 2'd1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_s_ready   <= 1'b1;
          r_m_valid   <= 1'b0;
          r_occupancy <= 2'd0;
        end
      endcase
    end
  end

  assign S_READY   = r_s_ready;
  assign M_VALID   = r_m_valid;
  assign M_DATA    = r_out_data;
  assign OCCUPANCY = r_occupancy;

endmodule

// File: tb/tb_pipeline_skid_buffer.sv
// Directed + random bench for pipeline_skid_buffer with a queue scoreboard on the stream.
module tb_pipeline_skid_buffer;

  logic        CLK;
  logic        RESET;
  logic        S_VALID;
  logic        S_READY;
  logic [15:0] S_DATA;
  logic        M_VALID;
  logic        M_READY;
  logic [15:0] M_DATA;
  logic [1:0]  OCCUPANCY;

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_pop    = 0;
  logic [15:0] sb_q[$];

  pipeline_skid_buffer #(.DATA_WIDTH(16), .RESET_DATA(16'h0000)) dut (
    .CLK(CLK), .RESET(RESET),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
    .OCCUPANCY(OCCUPANCY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Inputs change 1 time unit after each rising edge, so the falling edge sees
  // exactly what the next rising edge will sample.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data  = 16'h0;
  always @(negedge CLK) begin
    if (RESET) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stable_mdata", {16'h0, M_DATA}, {16'h0, prev_data});
      if (S_VALID && S_READY) begin
        sb_q.push_back(S_DATA);
        n_push++;
      end
      if (M_VALID && M_READY) begin
        n_pop++;
        if (sb_q.size() == 0) check("pop_from_empty_sb", {16'h0, M_DATA}, 32'hFFFF_FFFF);
        else check("sb_order", {16'h0, M_DATA}, {16'h0, sb_q.pop_front()});
      end
      prev_stall = M_VALID && !M_READY;
      prev_data  = M_DATA;
    end
  end

  initial begin
    int sent;
    int cycles;
    logic acc;

    RESET = 1'b1; S_VALID = 1'b0; M_READY = 1'b0; S_DATA = 16'h0;
    repeat (3) step();
    check("rst_m_valid", {31'h0, M_VALID}, 32'd0);
    check("rst_s_ready", {31'h0, S_READY}, 32'd0);
    check("rst_occ", {30'h0, OCCUPANCY}, 32'd0);
    check("rst_m_data", {16'h0, M_DATA}, 32'h0);

    RESET = 1'b0;
    step();
    check("post_rst_s_ready", {31'h0, S_READY}, 32'd1);
    check("post_rst_occ", {30'h0, OCCUPANCY}, 32'd0);

    // Back-to-back stream with M_READY held high.
    M_READY = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      S_VALID = 1'b1; S_DATA = 16'(i);
      step();
      check("stream_m_valid", {31'h0, M_VALID}, 32'd1);
      check("stream_m_data", {16'h0, M_DATA}, i);
      check("stream_occ", {30'h0, OCCUPANCY}, 32'd1);
      check("stream_s_ready", {31'h0, S_READY}, 32'd1);
    end
    S_VALID = 1'b0;
    step();
    check("stream_end_occ", {30'h0, OCCUPANCY}, 32'd0);
    check("stream_end_m_valid", {31'h0, M_VALID}, 32'd0);

    // Fill under backpressure.
    M_READY = 1'b0; S_VALID = 1'b1; S_DATA = 16'hAAAA;
    step();
    check("bp1_occ", {30'h0, OCCUPANCY}, 32'd1);
    check("bp1_m_data", {16'h0, M_DATA}, 32'hAAAA);
    S_DATA = 16'hBBBB;
    step();
    check("bp2_occ", {30'h0, OCCUPANCY}, 32'd2);
    check("bp2_s_ready", {31'h0, S_READY}, 32'd0);
    check("bp2_m_data", {16'h0, M_DATA}, 32'hAAAA);
    S_DATA = 16'hCCCC;
    step();
    check("bp3_occ", {30'h0, OCCUPANCY}, 32'd2);
    check("bp3_m_data", {16'h0, M_DATA}, 32'hAAAA);
    check("bp3_s_ready", {31'h0, S_READY}, 32'd0);

    // Drain from FULL, then 0xCCCC follows.
    M_READY = 1'b1;
    step();
    check("drain_m_data", {16'h0, M_DATA}, 32'hBBBB);
    check("drain_s_ready", {31'h0, S_READY}, 32'd1);
    check("drain_occ", {30'h0, OCCUPANCY}, 32'd1);
    step();
    check("follow_m_data", {16'h0, M_DATA}, 32'hCCCC);
    check("follow_occ", {30'h0, OCCUPANCY}, 32'd1);
    S_VALID = 1'b0;
    step();
    check("follow_end_occ", {30'h0, OCCUPANCY}, 32'd0);

    // Simultaneous accept and drain while BUSY.
    M_READY = 1'b0; S_VALID = 1'b1; S_DATA = 16'h0042;
    step();
    check("sim_hold_m_data", {16'h0, M_DATA}, 32'h0042);
    S_DATA = 16'h1234; M_READY = 1'b1;
    step();
    check("sim_m_data", {16'h0, M_DATA}, 32'h1234);
    check("sim_occ", {30'h0, OCCUPANCY}, 32'd1);
    check("sim_m_valid", {31'h0, M_VALID}, 32'd1);
    S_VALID = 1'b0;
    step();
    check("sim_end_occ", {30'h0, OCCUPANCY}, 32'd0);

    // Random stall traffic.
    sent = 0; cycles = 0;
    while (sent < 1000 && cycles < 20000) begin
      S_VALID = 1'($urandom_range(0, 1));
      S_DATA  = 16'($urandom);
      M_READY = 1'($urandom_range(0, 1));
      acc = S_VALID && S_READY;
      step();
      if (acc) sent++;
      cycles++;
    end
    check("rand_sent_all", sent, 32'd1000);
    S_VALID = 1'b0; M_READY = 1'b1;
    cycles = 0;
    while (OCCUPANCY != 2'd0 && cycles < 10) begin
      step();
      cycles++;
    end
    check("rand_drained_occ", {30'h0, OCCUPANCY}, 32'd0);
    check("rand_sb_empty", sb_q.size(), 32'd0);
    check("rand_push_pop", n_pop, n_push);

    // Reset mid-operation from FULL.
    M_READY = 1'b0; S_VALID = 1'b1; S_DATA = 16'h5555;
    step();
    S_DATA = 16'h6666;
    step();
    check("mid_full_occ", {30'h0, OCCUPANCY}, 32'd2);
    RESET = 1'b1; S_DATA = 16'h7777; M_READY = 1'b1;
    step();
    check("mid_rst_m_valid", {31'h0, M_VALID}, 32'd0);
    check("mid_rst_occ", {30'h0, OCCUPANCY}, 32'd0);
    check("mid_rst_m_data", {16'h0, M_DATA}, 32'h0);
    check("mid_rst_s_ready", {31'h0, S_READY}, 32'd0);
    RESET = 1'b0; S_VALID = 1'b0;
    step();
    check("mid_rel_s_ready", {31'h0, S_READY}, 32'd1);
    check("mid_rel_m_valid", {31'h0, M_VALID}, 32'd0);
    step();
    check("mid_rel_sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_skid_buffer.md
Name: pipeline_skid_buffer

Overview:
Elastic valid/ready pipeline stage between a delay-line register chain and a consumer that may apply backpressure, e.g. a PE array or write-back path. Registers data and breaks the combinational ready path. Sustains one transfer per cycle with a two-entry store: an output register plus a skid register. Used wherever a fixed-latency stream must cross into a stallable consumer.

Parameters:
DATA_WIDTH, 16, width of the data word in bits
RESET_DATA, 0, value loaded into the output and skid registers on reset

Ports:
CLK  input  1  clock; all logic on the rising edge
RESET  input  1  synchronous, active-high reset
S_VALID  input  1  upstream data valid
S_READY  output  1  buffer can accept; registered, no combinational path from M_READY
S_DATA  input  DATA_WIDTH  upstream data
M_VALID  output  1  downstream data valid; registered
M_READY  input  1  downstream accepts
M_DATA  output  DATA_WIDTH  downstream data; driven directly from the output register
OCCUPANCY  output  2  number of words held: 0, 1 or 2

Behaviour:
- Reset (RESET high at a rising edge): state EMPTY, M_VALID=0, S_READY=0, M_DATA=RESET_DATA, skid=RESET_DATA, OCCUPANCY=0. The first edge with RESET low sets S_READY=1.
- accept = S_VALID & S_READY. drain = M_VALID & M_READY.
- State EMPTY (S_READY=1, M_VALID=0, OCCUPANCY=0):
  - accept: output reg <= S_DATA; go to BUSY.
  - otherwise: hold.
- State BUSY (S_READY=1, M_VALID=1, OCCUPANCY=1):
  - accept & drain: output reg <= S_DATA; stay in BUSY.
  - accept & !drain: skid <= S_DATA, S_READY <= 0; go to FULL.
  - drain & !accept: go to EMPTY.
  - neither: hold.
- State FULL (S_READY=0, M_VALID=1, OCCUPANCY=2):
  - drain: output reg <= skid, S_READY <= 1; go to BUSY.
  - S_VALID is ignored; no accept is possible.
- Latency: a word accepted at edge N appears on M_DATA with M_VALID=1 after edge N (1 cycle) when the buffer was EMPTY, or when it was BUSY and draining.
- Throughput: 1 word/cycle while M_READY is held high.
- Ordering: strict FIFO. No word is dropped or duplicated.
- Stability: while M_VALID=1 and M_READY=0, M_DATA holds constant.
- Skid register contents are don't-care outside FULL, but are never driven to X.
- S_DATA and S_VALID are sampled only at an edge where S_READY=1.
- Reset mid-operation: all held words are discarded. Outputs return to reset values at that edge, regardless of S_VALID or M_READY.
- OCCUPANCY is registered and matches the state encoding exactly.

Test Plan:
- Reset then stream: assert RESET 3 cycles, release, hold M_READY=1, push 0x0001..0x0008 back-to-back -> S_READY=1 from 1st cycle after release, M_DATA sequence 0x0001..0x0008 on consecutive cycles, each 1 cycle after acceptance, OCCUPANCY never 2.
- Backpressure fill: M_READY=0, push 0xAAAA then 0xBBBB -> OCCUPANCY 1 then 2, S_READY=0, M_DATA=0xAAAA stable; a third word 0xCCCC offered is not accepted.
- Drain from FULL: continue above, raise M_READY for 1 cycle -> M_DATA becomes 0xBBBB, S_READY=1, OCCUPANCY=1; next cycle 0xCCCC is accepted and follows 0xBBBB.
- Simultaneous accept/drain in BUSY: one word held, S_VALID=1 with 0x1234 and M_READY=1 same cycle -> state stays BUSY, M_DATA=0x1234 next cycle, OCCUPANCY=1.
- Random stall: 1000 random words, random S_VALID/M_READY at 50% -> scoreboard shows output equals input order, no loss or duplicates; M_DATA never changes while M_VALID&!M_READY.
- Reset mid-operation: FULL with 0x5555/0x6666, assert RESET one cycle -> next cycle M_VALID=0, OCCUPANCY=0, M_DATA=RESET_DATA, S_READY=0 then 1; 0x5555/0x6666 never appear.
